prio_mixer: RTL and testbench

Pixel-side consumer of the 256x4 sprite/tile priority table. It builds the priority-table address from the per-pixel layer transparency flags and sprite priority bits, reads the stored 4-bit code, and selects the winning layer colour. The table is held internally and filled through a byte-serial download port with a load state machine. Until the table is fully loaded, a fixed fallback priority applies.

---
 rtl/prio_mixer.sv | 103 ++++++++++
 tb/tb_prio_mixer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/prio_mixer.sv
// prio_mixer: priority-table driven layer mixer with byte-serial table download
module prio_mixer #(
    parameter int COLOR_W = 11
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               PXL_CE,
    input  logic               DL_WR,
    input  logic [7:0]         DL_ADDR,
    input  logic [3:0]         DL_DATA,
    input  logic [2:0]         OBP,
    input  logic [COLOR_W-1:0] FIX_COL,
    input  logic [COLOR_W-1:0] OBJ_COL,
    input  logic [COLOR_W-1:0] VB_COL,
    input  logic [COLOR_W-1:0] VA_COL,
    output logic [COLOR_W-1:0] PIX_COL,
    output logic [2:0]         PIX_LAYER,
    output logic               PIX_VALID,
    output logic               TBL_READY,
    output logic               DL_ERR
);
    typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;
    state_t state;
    logic [7:0] count;
    logic [3:0] mem [256];
    logic we;
    logic [COLOR_W-1:0] cin [4];
    logic [COLOR_W-1:0] c1 [4];
    logic [COLOR_W-1:0] c2 [4];
    logic [3:0] nin, n1, n2;
    logic [7:0] a1;
    logic [3:0] q;
    logic v1, v2;
    logic [2:0] fb, sel;
    logic unused;

    assign unused = q[3];
    assign we = DL_WR && !RST && (state == READY || DL_ADDR == count);

    // layer index 0..3 = FIX, OBJ, VB, VA; n flags mark transparent pens
    always_comb begin
        cin[0] = FIX_COL;
        cin[1] = OBJ_COL;
        cin[2] = VB_COL;
        cin[3] = VA_COL;
        for (int i = 0; i < 4; i++) nin[i] = cin[i][3:0] == 4'd0;
    end

    // fixed-priority fallback, otherwise the stored code decides
    always_comb begin
        fb = !n2[0] ? 3'd0 : !n2[1] ? 3'd1 : !n2[2] ? 3'd2 : !n2[3] ? 3'd3 : 3'd4;
        sel = TBL_READY ? q[2:0] : fb;
    end

    // table storage has no reset; writes land even while the pixel path stalls
    always_ff @(posedge CLK) begin
        if (we) mem[DL_ADDR] <= DL_DATA;
    end

    // download state machine: in-order fill, then free single-entry patches
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= EMPTY;
            count <= '0;
            TBL_READY <= 1'b0;
            DL_ERR <= 1'b0;
        end else if (DL_WR && state != READY) begin
            if (DL_ADDR == count) begin
                count <= count + 8'd1;
                if (state == EMPTY) DL_ERR <= 1'b0;
                state <= (count == 8'hFF) ? READY : LOADING;
                TBL_READY <= count == 8'hFF;
            end else begin
                state <= EMPTY;
                count <= '0;
                DL_ERR <= 1'b1;
            end
        end
    end

    // three-tick pixel pipeline: address, table read, select
    always_ff @(posedge CLK) begin
        if (RST) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            PIX_VALID <= 1'b0;
            PIX_COL <= '0;
            PIX_LAYER <= 3'd4;
        end else if (PXL_CE) begin
            c1 <= cin;
            n1 <= nin;
            a1 <= {1'b0, OBP[0], OBP[1], OBP[2], nin[0], nin[1], nin[2], nin[3]};
            v1 <= 1'b1;
            q <= mem[a1];
            c2 <= c1;
            n2 <= n1;
            v2 <= v1;
            PIX_COL <= sel[2] ? '0 : c2[sel[1:0]];
            PIX_LAYER <= sel[2] ? 3'd4 : sel;
            PIX_VALID <= v2;
        end
    end
endmodule

// File: tb/tb_prio_mixer.sv
// tb_prio_mixer: directed scoreboard bench for prio_mixer
module tb_prio_mixer;
    localparam int W = 11;
    logic clk = 1'b0, rst = 1'b1, pxl_ce = 1'b0, dl_wr = 1'b0;
    logic [7:0] dl_addr = '0;
    logic [3:0] dl_data = '0;
    logic [2:0] obp = '0;
    logic [W-1:0] fix_col = '0, obj_col = '0, vb_col = '0, va_col = '0;
    logic [W-1:0] pix_col;
    logic [2:0] pix_layer;
    logic pix_valid, tbl_ready, dl_err;
    typedef struct {
        bit chk;
        logic [2:0] layer;
        logic [W-1:0] col;
    } exp_t;
    exp_t sb[$];
    int tests = 0, fails = 0;

    prio_mixer #(.COLOR_W(W)) dut (
        .CLK(clk), .RST(rst), .PXL_CE(pxl_ce), .DL_WR(dl_wr),
        .DL_ADDR(dl_addr), .DL_DATA(dl_data), .OBP(obp),
        .FIX_COL(fix_col), .OBJ_COL(obj_col), .VB_COL(vb_col), .VA_COL(va_col),
        .PIX_COL(pix_col), .PIX_LAYER(pix_layer), .PIX_VALID(pix_valid),
        .TBL_READY(tbl_ready), .DL_ERR(dl_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // one pixel per call; chk=0 marks flush pixels whose result is irrelevant
    task automatic pix(input logic [2:0] o, input logic [W-1:0] f, j, v, a,
                       input bit chk, input logic [2:0] el, input logic [W-1:0] ec);
        obp = o; fix_col = f; obj_col = j; vb_col = v; va_col = a; pxl_ce = 1'b1;
        sb.push_back('{chk, el, ec});
        @(posedge clk); #1;
    endtask

    task automatic flush();
        pix(3'd0, 11'h0, 11'h0, 11'h0, 11'h0, 1'b0, 3'd4, 11'h0);
        pix(3'd0, 11'h0, 11'h0, 11'h0, 11'h0, 1'b0, 3'd4, 11'h0);
    endtask

    task automatic idle(input int n);
        pxl_ce = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] ad, input logic [3:0] d);
        dl_wr = 1'b1; dl_addr = ad; dl_data = d;
        @(posedge clk); #1;
        dl_wr = 1'b0;
    endtask

    task automatic do_reset();
        pxl_ce = 1'b0; rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pix_col"}, pix_col, 0);
        check({tag, "_pix_layer"}, pix_layer, 4);
        check({tag, "_pix_valid"}, pix_valid, 0);
        check({tag, "_tbl_ready"}, tbl_ready, 0);
        check({tag, "_dl_err"}, dl_err, 0);
    endtask

    // monitor: pops one expectation per emitted pixel
    initial begin
        logic ce_s, rst_s;
        exp_t e;
        forever begin
            @(posedge clk);
            ce_s = pxl_ce;
            rst_s = rst;
            #2;
            if (ce_s && !rst_s && pix_valid) begin
                if (sb.size() == 0) check("unexpected_pixel", 1, 0);
                else begin
                    e = sb.pop_front();
                    if (e.chk) begin
                        check("pix_layer", pix_layer, e.layer);
                        check("pix_col", pix_col, e.col);
                    end
                end
            end
        end
    end

    initial begin
        do_reset();
        check_reset("rst0");
        // fallback before load
        pix(3'd0, 11'h000, 11'h125, 11'h3F1, 11'h000, 1'b1, 3'd1, 11'h125);
        pix(3'd0, 11'h000, 11'h125, 11'h3F1, 11'h000, 1'b1, 3'd1, 11'h125);
        check("valid_before_third_tick", pix_valid, 0);
        pix(3'd0, 11'h000, 11'h125, 11'h3F1, 11'h000, 1'b1, 3'd1, 11'h125);
        check("fb_valid", pix_valid, 1);
        check("fb_layer", pix_layer, 1);
        check("fb_col", pix_col, 'h125);
        check("fb_tbl_ready", tbl_ready, 0);
        pix(3'd0, 11'h7F0, 11'h100, 11'h020, 11'h300, 1'b1, 3'd4, 11'h000);
        pix(3'd5, 11'h7A1, 11'h125, 11'h3F1, 11'h055, 1'b1, 3'd0, 11'h7A1);
        pix(3'd0, 11'h000, 11'h000, 11'h0A0, 11'h055, 1'b1, 3'd3, 11'h055);
        pix(3'd0, 11'h000, 11'h000, 11'h0A2, 11'h055, 1'b1, 3'd2, 11'h0A2);
        // stall: outputs hold while inputs move
        pxl_ce = 1'b0;
        for (int i = 0; i < 10; i++) begin
            fix_col = 11'(i * 37 + 1); obj_col = 11'(i * 91 + 3); obp = 3'(i);
            @(posedge clk); #1;
        end
        check("stall_layer", pix_layer, 0);
        check("stall_col", pix_col, 'h7A1);
        check("stall_valid", pix_valid, 1);
        flush();
        idle(1);
        // download error sequence
        wr(8'd0, 4'h3);
        check("err_after_start", dl_err, 0);
        wr(8'd1, 4'h2);
        wr(8'd3, 4'h0);
        check("err_set", dl_err, 1);
        check("err_not_ready", tbl_ready, 0);
        wr(8'd5, 4'h6);
        check("err_sticky_empty", dl_err, 1);
        wr(8'd0, 4'h3);
        check("err_cleared_restart", dl_err, 0);
        for (int i = 1; i < 100; i++) wr(8'(i), 4'(i) ^ 4'h3);
        // reset mid-load
        do_reset();
        check_reset("rst_midload");
        wr(8'd50, 4'h1);
        check("empty_after_reset", dl_err, 1);
        for (int i = 0; i < 255; i++) wr(8'(i), 4'(i) ^ 4'h3);
        check("not_ready_before_last", tbl_ready, 0);
        check("err_cleared_load", dl_err, 0);
        wr(8'hFF, 4'hF ^ 4'h3);
        check("ready_after_last", tbl_ready, 1);
        // table-driven selection
        pix(3'd0, 11'h101, 11'h202, 11'h303, 11'h404, 1'b1, 3'd3, 11'h404);
        pix(3'd0, 11'h7F0, 11'h100, 11'h020, 11'h300, 1'b1, 3'd4, 11'h000);
        pix(3'd0, 11'h101, 11'h202, 11'h303, 11'h400, 1'b1, 3'd2, 11'h303);
        pix(3'd0, 11'h101, 11'h202, 11'h300, 11'h400, 1'b1, 3'd0, 11'h101);
        pix(3'd5, 11'h101, 11'h202, 11'h300, 11'h404, 1'b1, 3'd1, 11'h202);
        flush();
        idle(1);
        // patches in READY, including OBP bit placement
        wr(8'h0F, 4'h4);
        wr(8'h40, 4'h0);
        wr(8'h10, 4'h1);
        check("ready_after_patch", tbl_ready, 1);
        pix(3'd0, 11'h7F0, 11'h100, 11'h020, 11'h300, 1'b1, 3'd4, 11'h000);
        pix(3'd1, 11'h101, 11'h202, 11'h303, 11'h404, 1'b1, 3'd0, 11'h101);
        pix(3'd4, 11'h101, 11'h202, 11'h303, 11'h404, 1'b1, 3'd1, 11'h202);
        pix(3'd2, 11'h101, 11'h202, 11'h303, 11'h404, 1'b1, 3'd3, 11'h404);
        // same-cycle patch of entry 0: in-flight read sees old code
        pix(3'd0, 11'h101, 11'h202, 11'h303, 11'h404, 1'b1, 3'd3, 11'h404);
        dl_wr = 1'b1; dl_addr = 8'h00; dl_data = 4'h0;
        pix(3'd0, 11'h101, 11'h202, 11'h303, 11'h404, 1'b1, 3'd0, 11'h101);
        dl_wr = 1'b0;
        pix(3'd0, 11'h101, 11'h202, 11'h303, 11'h404, 1'b1, 3'd0, 11'h101);
        flush();
        idle(3);
        check("final_ready", tbl_ready, 1);
        check("final_err", dl_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
